// File: rtl/pipe_hazard_if.sv
// Pipeline-to-hazard-controller signal bundle: stage control fields in, freeze/flush/forward/memory controls out.
interface pipe_hazard_if;
  logic [1:0]  id_src1;
  logic [1:0]  id_src2;
  logic        id_two_src;
  logic [1:0]  exe_src1;
  logic [1:0]  exe_src2;
  logic        exe_wb_en;
  logic        exe_mem_r_en;
  logic [1:0]  exe_dest;
  logic        exe_branch_taken;
  logic        mem_wb_en;
  logic        mem_mem_r_en;
  logic        mem_mem_w_en;
  logic [1:0]  mem_dest;
  logic        wb_wb_en;
  logic [1:0]  wb_dest;
  logic        mem_ready;

  logic        pc_freeze;
  logic        ifid_freeze;
  logic        idex_freeze;
  logic        exmem_freeze;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        mem_req;
  logic        mem_abort;
  logic        mem_err;
  logic [15:0] stall_cnt;

  // Pipeline side
  modport master (
    output id_src1, id_src2, id_two_src, exe_src1, exe_src2, exe_wb_en,
           exe_mem_r_en, exe_dest, exe_branch_taken, mem_wb_en, mem_mem_r_en,
           mem_mem_w_en, mem_dest, wb_wb_en, wb_dest, mem_ready,
    input  pc_freeze, ifid_freeze, idex_freeze, exmem_freeze, ifid_flush,
           idex_flush, memwb_flush, fwd_a_sel, fwd_b_sel, mem_req, mem_abort,
           mem_err, stall_cnt
  );

  // Hazard controller side
  modport slave (
    input  id_src1, id_src2, id_two_src, exe_src1, exe_src2, exe_wb_en,
           exe_mem_r_en, exe_dest, exe_branch_taken, mem_wb_en, mem_mem_r_en,
           mem_mem_w_en, mem_dest, wb_wb_en, wb_dest, mem_ready,
    output pc_freeze, ifid_freeze, idex_freeze, exmem_freeze, ifid_flush,
           idex_flush, memwb_flush, fwd_a_sel, fwd_b_sel, mem_req, mem_abort,
           mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 8-bit 4-register pipelined core: freezes, flushes,
// EXE operand forwarding, data-memory handshake with timeout, saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input logic          clk,
  input logic          rst,
  pipe_hazard_if.slave bus
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic mem_op_c, abort_c, mstall_c, lu_c;
  logic pc_freeze_c, ifid_freeze_c, idex_freeze_c, exmem_freeze_c;
  logic ifid_flush_c, idex_flush_c, memwb_flush_c, mem_abort_c, mem_req_c;
  logic [1:0] fwd_a_c, fwd_b_c;
  logic unused_exe_wb_en_c;

  // The EXE write-back enable plays no role in hazard detection.
  assign unused_exe_wb_en_c = bus.exe_wb_en;

  function automatic logic [1:0] fwd_sel(input logic [1:0] src,
                                         input logic       m_wb,
                                         input logic       m_rd,
                                         input logic [1:0] m_dest,
                                         input logic       w_wb,
                                         input logic [1:0] w_dest);
    logic [1:0] sel;
    sel = 2'd0;
    if (m_wb && !m_rd && (m_dest == src)) sel = 2'd1;
    else if (w_wb && (w_dest == src))     sel = 2'd2;
    return sel;
  endfunction

  // Hazard conditions; the timeout takes the last wait slot instead of a stall.
  always_comb begin
    mem_op_c = bus.mem_mem_r_en | bus.mem_mem_w_en;
    abort_c  = mem_op_c & ~bus.mem_ready & (wait_cnt_q == WAIT_LAST);
    mstall_c = mem_op_c & ~bus.mem_ready & ~abort_c;
    lu_c     = bus.exe_mem_r_en &
               ((bus.id_src1 == bus.exe_dest) |
                (bus.id_two_src & (bus.id_src2 == bus.exe_dest)));
  end

  // Prioritised freeze/flush decode; everything forced low during reset.
  always_comb begin
    pc_freeze_c    = 1'b0;
    ifid_freeze_c  = 1'b0;
    idex_freeze_c  = 1'b0;
    exmem_freeze_c = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_flush_c   = 1'b0;
    memwb_flush_c  = 1'b0;
    mem_abort_c    = 1'b0;
    mem_req_c      = 1'b0;
    fwd_a_c        = 2'd0;
    fwd_b_c        = 2'd0;
    if (!rst) begin
      mem_req_c = mem_op_c;
      fwd_a_c   = fwd_sel(bus.exe_src1, bus.mem_wb_en, bus.mem_mem_r_en,
                          bus.mem_dest, bus.wb_wb_en, bus.wb_dest);
      fwd_b_c   = fwd_sel(bus.exe_src2, bus.mem_wb_en, bus.mem_mem_r_en,
                          bus.mem_dest, bus.wb_wb_en, bus.wb_dest);
      if (mstall_c) begin
        pc_freeze_c    = 1'b1;
        ifid_freeze_c  = 1'b1;
        idex_freeze_c  = 1'b1;
        exmem_freeze_c = 1'b1;
        memwb_flush_c  = 1'b1;
      end else begin
        if (abort_c) begin
          mem_abort_c   = 1'b1;
          memwb_flush_c = 1'b1;
        end
        if (bus.exe_branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (lu_c) begin
          pc_freeze_c   = 1'b1;
          ifid_freeze_c = 1'b1;
          idex_flush_c  = 1'b1;
        end
      end
    end
  end

  // Memory-wait FSM and registered bookkeeping next-state.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    mem_err_d   = mem_err_q | abort_c;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN:      if (mstall_c)  state_d = MEM_WAIT;
      MEM_WAIT: if (!mstall_c) state_d = RUN;
      default:                 state_d = RUN;
    endcase
    if (mstall_c) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    if (pc_freeze_c && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_freeze    = pc_freeze_c;
  assign bus.ifid_freeze  = ifid_freeze_c;
  assign bus.idex_freeze  = idex_freeze_c;
  assign bus.exmem_freeze = exmem_freeze_c;
  assign bus.ifid_flush   = ifid_flush_c;
  assign bus.idex_flush   = idex_flush_c;
  assign bus.memwb_flush  = memwb_flush_c;
  assign bus.fwd_a_sel    = fwd_a_c;
  assign bus.fwd_b_sel    = fwd_b_c;
  assign bus.mem_req      = mem_req_c;
  assign bus.mem_abort    = mem_abort_c;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned MT = 8;

  logic clk = 1'b0;
  logic rst;
  pipe_hazard_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: consecutive stalled cycles of the current access, sticky error, stall count.
  int unsigned m_wait  = 0;
  bit          m_err   = 1'b0;
  int unsigned m_stall = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [1:0] src);
    if (bus.mem_wb_en && !bus.mem_mem_r_en && bus.mem_dest == src) return 2'd1;
    if (bus.wb_wb_en && bus.wb_dest == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic idle();
    bus.id_src1 = 2'd0; bus.id_src2 = 2'd0; bus.id_two_src = 1'b0;
    bus.exe_src1 = 2'd0; bus.exe_src2 = 2'd0; bus.exe_wb_en = 1'b0;
    bus.exe_mem_r_en = 1'b0; bus.exe_dest = 2'd0; bus.exe_branch_taken = 1'b0;
    bus.mem_wb_en = 1'b0; bus.mem_mem_r_en = 1'b0; bus.mem_mem_w_en = 1'b0;
    bus.mem_dest = 2'd0; bus.wb_wb_en = 1'b0; bus.wb_dest = 2'd0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.id_src1 = 2'($urandom); bus.id_src2 = 2'($urandom);
    bus.id_two_src = 1'($urandom);
    bus.exe_src1 = 2'($urandom); bus.exe_src2 = 2'($urandom);
    bus.exe_wb_en = 1'($urandom);
    bus.exe_mem_r_en = ($urandom_range(0, 2) == 0);
    bus.exe_dest = 2'($urandom);
    bus.exe_branch_taken = ($urandom_range(0, 7) == 0);
    bus.mem_wb_en = 1'($urandom);
    bus.mem_mem_r_en = ($urandom_range(0, 3) == 0);
    bus.mem_mem_w_en = ($urandom_range(0, 3) == 0);
    bus.mem_dest = 2'($urandom);
    bus.wb_wb_en = 1'($urandom);
    bus.wb_dest = 2'($urandom);
    bus.mem_ready = ($urandom_range(0, 5) == 0);
  endtask

  // Called just after a falling edge with inputs applied; checks, advances the model, waits a cycle.
  task automatic step(input bit do_chk);
    bit mem_op, notready, ab, ms, lu;
    bit [3:0] frz;
    bit [2:0] fl;
    logic [8:0] e_ctl, o_ctl;
    logic [1:0] e_fa, e_fb;
    #1;
    mem_op   = bus.mem_mem_r_en || bus.mem_mem_w_en;
    notready = mem_op && !bus.mem_ready;
    ab       = notready && (m_wait == MT - 1);
    ms       = notready && !ab;
    lu       = bus.exe_mem_r_en && (bus.id_src1 == bus.exe_dest ||
               (bus.id_two_src && bus.id_src2 == bus.exe_dest));
    frz = 4'b0000;
    fl  = 3'b000;
    if (ms) begin
      frz = 4'b1111; fl = 3'b001;
    end else begin
      if (ab) fl[0] = 1'b1;
      if (bus.exe_branch_taken) fl[2:1] = 2'b11;
      else if (lu) begin frz = 4'b1100; fl[1] = 1'b1; end
    end
    e_ctl = {frz, fl, ab, mem_op};
    e_fa  = ref_fwd(bus.exe_src1);
    e_fb  = ref_fwd(bus.exe_src2);
    if (rst) begin
      e_ctl = '0; e_fa = 2'd0; e_fb = 2'd0; frz = 4'b0000; ab = 1'b0; ms = 1'b0;
      m_wait = 0; m_err = 1'b0; m_stall = 0;
    end
    o_ctl = {bus.pc_freeze, bus.ifid_freeze, bus.idex_freeze, bus.exmem_freeze,
             bus.ifid_flush, bus.idex_flush, bus.memwb_flush, bus.mem_abort, bus.mem_req};
    if (do_chk) begin
      chk_eq("ctrl", 32'(o_ctl), 32'(e_ctl));
      chk_eq("fwd_a", 32'(bus.fwd_a_sel), 32'(e_fa));
      chk_eq("fwd_b", 32'(bus.fwd_b_sel), 32'(e_fb));
      chk_eq("mem_err", 32'(bus.mem_err), 32'(m_err));
      chk_eq("stall_cnt", 32'(bus.stall_cnt), m_stall);
    end
    if (!rst) begin
      m_wait = ms ? m_wait + 1 : 0;
      if (ab) m_err = 1'b1;
      if (frz[3] && m_stall < 65535) m_stall++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    rand_inputs(); step(1);
    rand_inputs(); step(1);
    rst = 1'b0;

    // Load-use bubble, then the load forwards from WB.
    idle(); bus.exe_mem_r_en = 1'b1; bus.exe_dest = 2'd1; bus.id_src1 = 2'd1;
    #1 chk_eq("lu_freeze", 32'(bus.pc_freeze), 32'd1);
    step(1);
    idle(); bus.wb_wb_en = 1'b1; bus.wb_dest = 2'd1; bus.exe_src1 = 2'd1;
    #1 chk_eq("lu_fwd_wb", 32'(bus.fwd_a_sel), 32'd2);
    step(1);

    // EXE/MEM forward wins over MEM/WB.
    idle(); bus.mem_wb_en = 1'b1; bus.mem_dest = 2'd2; bus.wb_wb_en = 1'b1;
    bus.wb_dest = 2'd2; bus.exe_src1 = 2'd2; bus.exe_src2 = 2'd2;
    step(1);
    bus.mem_mem_r_en = 1'b1; bus.mem_ready = 1'b1; step(1);

    // Store waits 3 cycles, then completes.
    idle(); bus.mem_mem_w_en = 1'b1;
    repeat (3) step(1);
    bus.mem_ready = 1'b1; step(1);
    idle(); step(1);

    // Ready arrives exactly in the last wait slot: completes, no abort.
    idle(); bus.mem_mem_r_en = 1'b1;
    repeat (MT - 1) step(1);
    bus.mem_ready = 1'b1;
    #1 chk_eq("late_ready_no_abort", 32'(bus.mem_abort), 32'd0);
    step(1);
    idle(); step(1);

    // Never-ready access times out; branch + load-use evaluated in the abort cycle.
    idle(); bus.mem_mem_w_en = 1'b1;
    repeat (MT - 1) step(1);
    bus.exe_branch_taken = 1'b1; bus.exe_mem_r_en = 1'b1;
    #1 chk_eq("abort_pulse", 32'(bus.mem_abort), 32'd1);
    step(1);
    idle();
    #1 chk_eq("err_sticky", 32'(bus.mem_err), 32'd1);
    step(1); step(1);

    // Branch beats load-use; under a memory stall it waits for ready.
    idle(); bus.exe_branch_taken = 1'b1; bus.exe_mem_r_en = 1'b1;
    step(1);
    bus.mem_mem_r_en = 1'b1;
    step(1); step(1);
    bus.mem_ready = 1'b1; step(1);

    // Reset in the middle of a wait.
    idle(); bus.mem_mem_w_en = 1'b1;
    repeat (3) step(1);
    rst = 1'b1; step(1); step(1);
    rst = 1'b0; idle(); step(1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;

    // Stall counter saturation via a held load-use.
    do_reset();
    idle(); bus.exe_mem_r_en = 1'b1; bus.exe_dest = 2'd3; bus.id_src1 = 2'd3;
    repeat (65540) step(0);
    step(1);
    #1 chk_eq("stall_sat", 32'(bus.stall_cnt), 32'hFFFF);
    idle(); step(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 8-bit, 4-register pipelined RISC core. It watches the ID, EXE, MEM and WB stage control fields and issues per-stage freeze and flush commands to the pipeline registers. It also generates operand-forwarding selects for the EXE stage and runs the data-memory request/ready handshake, with a timeout. A saturating counter records stall cycles.

## Interface
Parameters:
- MEM_TIMEOUT, 8, number of consecutive not-ready memory cycles before abort; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_src1, id_src2  in  2 each  source registers of the instruction in ID.
- id_two_src  in  1  the ID instruction reads id_src2.
- exe_src1, exe_src2  in  2 each  source registers of the instruction in EXE.
- exe_wb_en, exe_mem_r_en  in  1 each  control bits of the instruction in EXE.
- exe_dest  in  2  destination register of the instruction in EXE.
- exe_branch_taken  in  1  the branch in EXE is resolved taken.
- mem_wb_en, mem_mem_r_en, mem_mem_w_en  in  1 each  outputs of the EXE/MEM register.
- mem_dest  in  2  destination field of the EXE/MEM register.
- wb_wb_en  in  1  write-back enable of the MEM/WB register.
- wb_dest  in  2  destination field of the MEM/WB register.
- mem_ready  in  1  data memory completes the current access this cycle.
- pc_freeze, ifid_freeze, idex_freeze, exmem_freeze  out  1 each  hold the named register.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all zeros) into the named register.
- fwd_a_sel, fwd_b_sel  out  2 each  EXE operand select: 0 = register file, 1 = EXE/MEM ALU result, 2 = MEM/WB write-back value.
- mem_req  out  1  data-memory access request.
- mem_abort  out  1  one-cycle pulse when the current access times out.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  16  count of cycles with pc_freeze asserted.

## Operation
- mem_op = mem_mem_r_en | mem_mem_w_en. mem_req = mem_op (level).
- A memory access completes on any cycle where mem_req and mem_ready are both 1. Back-to-back accesses keep mem_req high continuously.
- abort = mem_op & !mem_ready & (wait_cnt == MEM_TIMEOUT-1).
- mstall = mem_op & !mem_ready & !abort.
- lu = exe_mem_r_en & (id_src1 == exe_dest | (id_two_src & id_src2 == exe_dest)).
- Outputs follow a priority order; only the first matching row applies.
  1. mstall: pc_freeze, ifid_freeze, idex_freeze and exmem_freeze are 1, and memwb_flush is 1. All other flushes are 0. A pending branch or load-use is deferred because those instructions are held in place.
  2. abort: mem_abort is 1 and memwb_flush is 1, which discards the access. No freezes are asserted. Branch and load-use are then evaluated as in rows 3 and 4 in the same cycle.
  3. exe_branch_taken: ifid_flush and idex_flush are 1.
  4. lu: pc_freeze and ifid_freeze are 1, and idex_flush is 1.
  5. Otherwise all freeze and flush outputs are 0.
- Forwarding is combinational and evaluated independently for each operand. For fwd_a_sel (using exe_src1):
  - 1 if mem_wb_en & !mem_mem_r_en & mem_dest == exe_src1.
  - Otherwise 2 if wb_wb_en & wb_dest == exe_src1.
  - Otherwise 0.
  - fwd_b_sel is identical using exe_src2. The EXE/MEM match takes priority over the MEM/WB match.
- A load in MEM is never a forwarding source. The lu stall guarantees the dependent instruction meets the load only once the load is in WB.
- FSM states:
  - RUN: go to MEM_WAIT on mstall.
  - MEM_WAIT: go to RUN when mem_ready or abort. Stay on mstall.
- wait_cnt (8 bit) increments on each mstall cycle and clears to 0 on any cycle without mstall.
- mem_err is set at the edge following abort and holds until rst.
- stall_cnt increments on every cycle with pc_freeze = 1 and saturates at 16'hFFFF.

## Timing
- Reset values: state RUN, wait_cnt 0, mem_err 0, stall_cnt 0.
- While rst is high, every combinational output (freezes, flushes, fwd selects, mem_req, mem_abort) is forced to 0.
- Reset asserted mid-wait aborts immediately, with no mem_abort pulse and no mem_err.
- All freeze, flush, forwarding, mem_req and mem_abort outputs are combinational, with zero latency from their inputs. mem_err and stall_cnt are registered and update one cycle later.
- Load-use costs exactly 1 bubble. A taken branch costs 2 bubbles.
- A never-ready access gives MEM_TIMEOUT-1 freeze cycles, then 1 abort cycle.
- If mem_ready rises on the same cycle that wait_cnt reaches MEM_TIMEOUT-1, the access completes and there is no abort.

## Test plan
- Load r1 in EXE (exe_mem_r_en=1, exe_dest=1), ID reads id_src1=1 -> pc_freeze=ifid_freeze=idex_flush=1 for 1 cycle. Next cycle the load is in WB and fwd_a_sel=2.
- ALU op to r2 in MEM (mem_wb_en=1, mem_dest=2) and WB also writes r2, with exe_src1=exe_src2=2 -> fwd_a_sel=fwd_b_sel=1.
- Store in MEM with mem_ready low for 3 cycles -> 3 cycles of all freezes plus memwb_flush, state MEM_WAIT, stall_cnt +3. On the 4th cycle (ready high) there are no freezes and the FSM returns to RUN.
- mem_ready held low with MEM_TIMEOUT=8 -> 7 freeze cycles, then mem_abort=1 with memwb_flush=1. mem_err=1 from the next cycle and stays 1.
- exe_branch_taken=1 together with a load-use condition -> only ifid_flush=idex_flush=1, pc_freeze=0. Repeat with mstall active -> freeze only, and the branch flush occurs on the cycle mem_ready rises.
- Assert rst during MEM_WAIT -> all outputs 0 immediately, and stall_cnt=0, state RUN after release. Separately, force 65540 stall cycles -> stall_cnt holds 16'hFFFF.
